// File: rtl/jk_mod_counter.sv
// ----------------------------------------------------------------------------
// jk_mod_counter
//
// Synchronous modulo-(MAX+1) up/down counter whose state bits are JK cells.
// Each cycle the block works out the next count, turns it into per-bit J/K
// excitation, and clocks the cells on the falling edge of clk. Reset is not a
// separate cell pin: it is pushed through the excitation path like any other
// next value.
//
// Parameters
//   WIDTH  counter width in bits (2..16)
//   MAX    terminal value, count range is 0..MAX (1 <= MAX <= 2^WIDTH-1)
//
// Ports
//   clk   in   clock, all state changes on the falling edge
//   rst   in   synchronous active-low reset, sampled on the falling edge
//   en    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   load  in   parallel load, takes priority over en
//   d     in   load value (saturated to MAX)
//   q     out  current count (JK cell outputs)
//   j     out  J excitation bus (combinational)
//   k     out  K excitation bus (combinational)
//   tc    out  terminal count (combinational)
//   wrap  out  registered one-cycle pulse after a wrap edge
// ----------------------------------------------------------------------------
module jk_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V = '0;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] n_d;
    logic             wrap_q;
    logic             at_max;
    logic             at_zero;

    // Next-value selection and excitation. Priority: reset, load, count, hold.
    always_comb begin
        n_d     = q_q;
        at_max  = (q_q == MAX_V);
        at_zero = (q_q == ZERO_V);

        if (!rst) begin
            n_d = ZERO_V;
        end else if (load) begin
            n_d = (d > MAX_V) ? MAX_V : d;
        end else if (en) begin
            if (up) begin
                // ">=" rather than "==" so an out-of-range count falls back to
                // zero, and q+1 is never formed at MAX so it cannot overflow.
                n_d = (q_q >= MAX_V) ? ZERO_V : (q_q + ONE_V);
            end else begin
                // Out-of-range values simply walk down until back in range.
                n_d = at_zero ? MAX_V : (q_q - ONE_V);
            end
        end

        // Set bits that must rise, clear bits that must fall, otherwise 00.
        // The 11 code is never produced here.
        j  = n_d & ~q_q;
        k  = ~n_d & q_q;

        tc = rst & en & ~load & ((up & at_max) | (~up & at_zero));
    end

    // JK cells, one per bit. Full JK behaviour including toggle.
    for (genvar i = 0; i < WIDTH; i++) begin : g_jk_cell
        always_ff @(negedge clk) begin
            case ({j[i], k[i]})
                2'b00:   q_q[i] <= q_q[i];
                2'b01:   q_q[i] <= 1'b0;
                2'b10:   q_q[i] <= 1'b1;
                default: q_q[i] <= ~q_q[i];
            endcase
        end
    end

    // Wrap pulse trails tc by one clock; reset clears any pending pulse.
    always_ff @(negedge clk) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_jk_mod_counter
//
// Bench for jk_mod_counter (WIDTH=4, MAX=9). A behavioural model tracks the
// count as a plain integer and is compared against every DUT output on each
// rising edge (mid-cycle, away from the active falling edge). Directed
// sequences pin the model with hand-computed literals, then randomized
// stimulus runs against the model.
// ----------------------------------------------------------------------------
module tb_jk_mod_counter;

  localparam int WIDTH = 4;
  localparam int MAX   = 9;

  // clock / reset block
  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             tc;
  logic             wrap;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .j    (j),
    .k    (k),
    .tc   (tc),
    .wrap (wrap)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int cnt         = 0;
  int exp_wrap    = 0;
  bit model_valid = 1'b0;

  function automatic int next_val(input int c);
    if (!rst) return 0;
    if (load) return (int'(d) > MAX) ? MAX : int'(d);
    if (en) begin
      if (up) return (c >= MAX) ? 0 : c + 1;
      return (c == 0) ? MAX : c - 1;
    end
    return c;
  endfunction

  function automatic int tc_val(input int c);
    if (!rst || !en || load) return 0;
    return (up ? (c == MAX) : (c == 0)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int n;
    int t;
    n = next_val(cnt);
    t = tc_val(cnt);
    if (!rst) begin
      cnt         = 0;
      exp_wrap    = 0;
      model_valid = 1'b1;
    end else begin
      exp_wrap = t;
      cnt      = n;
    end
  end

  // scoreboard compare, every cycle once the model is valid
  always @(posedge clk) begin
    int n;
    if (model_valid) begin
      n = next_val(cnt);
      check("q", int'(q), cnt);
      check("wrap", int'(wrap), exp_wrap);
      check("tc", int'(tc), tc_val(cnt));
      check("j", int'(j), n & ~cnt & ((1 << WIDTH) - 1));
      check("k", int'(k), ~n & cnt & ((1 << WIDTH) - 1));
    end
  end

  // driver tasks
  task automatic set_in(input logic r, input logic e, input logic u,
                        input logic l, input logic [WIDTH-1:0] dv);
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    d    = dv;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    #1;

    // reset with en/load active
    tick();
    tick();
    check("rst_q", int'(q), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_j", int'(j), 0);

    // up wrap
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    repeat (9) tick();
    check("up_q9", int'(q), 9);
    check("up_tc9", int'(tc), 1);
    tick();
    check("up_wrap_q", int'(q), 0);
    check("up_wrap_pulse", int'(wrap), 1);
    check("up_tc0", int'(tc), 0);
    tick();
    check("up_q1", int'(q), 1);
    check("up_wrap_gone", int'(wrap), 0);

    // down wrap
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    check("dn_load0", int'(q), 0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    check("dn_tc", int'(tc), 1);
    check("dn_j", int'(j), 4'b1001);
    check("dn_k", int'(k), 4'b0000);
    tick();
    check("dn_q9", int'(q), 9);
    check("dn_wrap", int'(wrap), 1);
    tick();
    check("dn_q8", int'(q), 8);

    // load saturation
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd13);
    tick();
    check("sat_q", int'(q), 9);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    #1;
    check("ld_en_tc", int'(tc), 0);
    tick();
    check("ld_en_q", int'(q), 3);
    check("ld_en_wrap", int'(wrap), 0);

    // hold and excitation
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    check("hold_j", int'(j), 0);
    check("hold_k", int'(k), 0);
    repeat (5) tick();
    check("hold_q", int'(q), 6);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    #1;
    check("step78_j", int'(j), 4'b1000);
    check("step78_k", int'(k), 4'b0111);
    tick();
    check("step78_q", int'(q), 8);

    // mid-operation reset at q=9 with tc high
    tick();
    check("mid_q9", int'(q), 9);
    check("mid_tc", int'(tc), 1);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    #1;
    check("mid_tc_forced", int'(tc), 0);
    check("mid_j", int'(j), 0);
    check("mid_k", int'(k), 9);
    tick();
    check("mid_q0", int'(q), 0);
    check("mid_wrap", int'(wrap), 0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    check("mid_after_wrap", int'(wrap), 0);
    check("mid_after_q", int'(q), 1);

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 29) != 0),
             ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0),
             WIDTH'($urandom_range(0, 15)));
      tick();
    end

    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
